// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port (IF fetch vs MEM load/store).
// Define MEM_ARB_RR_EN for round-robin priority; default is fixed MEM-over-IF priority.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic mem_req,
    input  logic mem_we,
    input  logic ram_ready,
    input  logic err_clr,
    output logic port_sel,
    output logic ram_en,
    output logic ram_we,
    output logic if_done,
    output logic mem_done,
    output logic busy,
    output logic err
);

    typedef enum logic [1:0] {StIdle, StGntIf, StGntMem} state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic              port_sel_q, port_sel_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              complete;
    logic              timeout;
    logic              grant_mem;

    assign complete = (state_q != StIdle) && ram_ready;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    logic arb_last;

    // A completing transaction already counts as the most recent grant.
    assign arb_last     = complete ? (state_q == StGntMem) : last_grant_q;
    assign last_grant_d = complete ? (state_q == StGntMem) : last_grant_q;
    assign grant_mem    = (mem_req && if_req) ? ~arb_last : mem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign grant_mem = mem_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timeout  = 1'b0;
        if_done  = 1'b0;
        mem_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_req || if_req) begin
                    state_d = grant_mem ? StGntMem : StGntIf;
                    cnt_d   = '0;
                end
            end
            StGntIf, StGntMem: begin
                if (ram_ready) begin
                    // A requester that dropped its req mid-access gets no done pulse.
                    if_done  = (state_q == StGntIf) && if_req;
                    mem_done = (state_q == StGntMem) && mem_req;
                    cnt_d    = '0;
                    if (mem_req || if_req) begin
                        state_d = grant_mem ? StGntMem : StGntIf;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == TimeoutCnt) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mux select and enables are registered off the next state; select holds in idle.
    always_comb begin
        port_sel_d = port_sel_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        unique case (state_d)
            StGntIf: begin
                port_sel_d = 1'b0;
                ram_en_d   = 1'b1;
            end
            StGntMem: begin
                port_sel_d = 1'b1;
                ram_en_d   = 1'b1;
                ram_we_d   = mem_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            port_sel_q <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            port_sel_q <= port_sel_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign port_sel = port_sel_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=4); inputs change and
// outputs are sampled in the low half of the clock.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    logic if_req, mem_req, mem_we, ram_ready, err_clr;
    logic port_sel, ram_en, ram_we, if_done, mem_done, busy, err;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .TIMEOUT(4),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .ram_ready(ram_ready),
        .err_clr  (err_clr),
        .port_sel (port_sel),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .if_done  (if_done),
        .mem_done (mem_done),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock edge and land in the next low phase, settled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic exp_sel [4];

    initial begin
        rst_n = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        ram_ready = 1'b0; err_clr = 1'b0;
        step();
        step();
        check("rst_port_sel", port_sel, 1'b0);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        step();

        // Single IF read, ready on the third granted cycle.
        if_req = 1'b1;
        step();
        check("if_c1_sel", port_sel, 1'b0);
        check("if_c1_en", ram_en, 1'b1);
        check("if_c1_we", ram_we, 1'b0);
        check("if_c1_done", if_done, 1'b0);
        step();
        check("if_c2_done", if_done, 1'b0);
        step();
        ram_ready = 1'b1;
        #1;
        check("if_c3_done", if_done, 1'b1);
        check("if_c3_mdone", mem_done, 1'b0);
        if_req = 1'b0;
        step();
        ram_ready = 1'b0;
        #1;
        check("if_c4_busy", busy, 1'b0);
        check("if_c4_en", ram_en, 1'b0);
        check("if_c4_done", if_done, 1'b0);

        // Simultaneous requests: MEM write first, then IF with no idle bubble.
        if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
        step();
        check("sim_mem_sel", port_sel, 1'b1);
        check("sim_mem_we", ram_we, 1'b1);
        check("sim_mem_en", ram_en, 1'b1);
        ram_ready = 1'b1;
        #1;
        check("sim_mem_done", mem_done, 1'b1);
        check("sim_mem_ifdone", if_done, 1'b0);
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        check("sim_if_sel", port_sel, 1'b0);
        check("sim_if_we", ram_we, 1'b0);
        check("sim_if_busy", busy, 1'b1);
        check("sim_if_done", if_done, 1'b1);
        if_req = 1'b0;
        step();
        ram_ready = 1'b0;
        #1;
        check("sim_idle", busy, 1'b0);

        // Timeout: counter 0..3 increments, abort on the cycle it reads 4.
        mem_req = 1'b1;
        step();
        check("to_sel", port_sel, 1'b1);
        check("to_we", ram_we, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("to_wait_done", mem_done, 1'b0);
            check("to_wait_err", err, 1'b0);
            check("to_wait_busy", busy, 1'b1);
        end
        mem_req = 1'b0;
        step();
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_en", ram_en, 1'b0);
        step();
        step();
        check("to_err_sticky", err, 1'b1);
        err_clr = 1'b1;
        step();
        check("to_err_clr", err, 1'b0);
        err_clr = 1'b0;

        // Timeout coinciding with err_clr: set wins.
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) step();
        err_clr = 1'b1; mem_req = 1'b0;
        step();
        check("setwin_err", err, 1'b1);
        step();
        check("setwin_clr", err, 1'b0);
        err_clr = 1'b0;

        // ram_ready in idle is ignored.
        ram_ready = 1'b1;
        #1;
        check("idle_rdy_ifdone", if_done, 1'b0);
        check("idle_rdy_mdone", mem_done, 1'b0);
        step();
        check("idle_rdy_busy", busy, 1'b0);
        check("idle_rdy_err", err, 1'b0);
        ram_ready = 1'b0;

        // Continuous contention with ready every cycle; last completion was IF.
`ifdef MEM_ARB_RR_EN
        exp_sel[0] = 1'b1; exp_sel[1] = 1'b0; exp_sel[2] = 1'b1; exp_sel[3] = 1'b0;
`else
        exp_sel[0] = 1'b1; exp_sel[1] = 1'b1; exp_sel[2] = 1'b1; exp_sel[3] = 1'b1;
`endif
        if_req = 1'b1; mem_req = 1'b1; ram_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cont_sel", port_sel, exp_sel[i]);
            check("cont_mdone", mem_done, exp_sel[i]);
            check("cont_idone", if_done, ~exp_sel[i]);
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();
        ram_ready = 1'b0;
        #1;
        check("cont_idle", busy, 1'b0);

        // Reset asserted mid GNT_MEM aborts immediately.
        mem_req = 1'b1; mem_we = 1'b1;
        step();
        check("rstmid_en", ram_en, 1'b1);
        rst_n = 1'b0; ram_ready = 1'b1;
        #1;
        check("rstmid_en0", ram_en, 1'b0);
        check("rstmid_sel", port_sel, 1'b0);
        check("rstmid_we", ram_we, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_mdone", mem_done, 1'b0);
        mem_req = 1'b0; mem_we = 1'b0; ram_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rstmid_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
